// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, addresses the instruction ROM and queues
// {pc, instruction} pairs in a small prefetch FIFO presented to decode over valid/ready.
module instr_fetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [PTR_W-1:0]      r_rd_ptr, w_rd_ptr_nxt;
  logic [PTR_W-1:0]      r_wr_ptr, w_wr_ptr_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic                  w_push, w_pop;

  assign imem_addr  = r_fetch_pc;
  assign fetch_pc   = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst_data  = r_data_mem[r_rd_ptr];
  assign inst_pc    = r_pc_mem[r_rd_ptr];

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_pop  = inst_valid & inst_ready;
  assign w_push = fetch_en & ~redirect_valid & ((r_count < FULL_CNT) | w_pop);

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_count_nxt    = r_count;
    if (redirect_valid) begin
      // Flush: any same-cycle pop is acknowledged but its entry is simply dropped.
      w_fetch_pc_nxt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
      w_count_nxt    = '0;
    end else begin
      if (w_push) begin
        w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(4);
        w_wr_ptr_nxt   = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_data_mem[i] <= '0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        r_data_mem[r_wr_ptr] <= imem_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; ROM model returns addr ^ 32'hA5A5_0000.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        fetch_en, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc, fetch_pc;

  logic [31:0] w_imem_addr, w_imem_data;
  logic        w_inst_valid;
  logic [31:0] w_inst_data, w_inst_pc, w_fetch_pc;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign imem_data   = imem_addr ^ 32'hA5A5_0000;
  assign w_imem_data = w_imem_addr ^ 32'hA5A5_0000;

  instr_fetch_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_pc       (fetch_pc)
  );

  // Second instance exercises PC wrap from a reset PC at the top of the address space.
  instr_fetch_ctrl #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (w_imem_addr),
    .imem_data      (w_imem_data),
    .fetch_en       (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (w_inst_valid),
    .inst_ready     (1'b1),
    .inst_data      (w_inst_data),
    .inst_pc        (w_inst_pc),
    .fetch_pc       (w_fetch_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, ".pc"}, inst_pc, pc);
    check({tag, ".data"}, inst_data, pc ^ 32'hA5A5_0000);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #12;
    check("rst.valid", {31'b0, inst_valid}, 32'd0);
    check("rst.data", inst_data, 32'h0);
    check("rst.pc", inst_pc, 32'h0);
    check("rst.fetch_pc", fetch_pc, 32'h0);
    check("rst.imem_addr", imem_addr, 32'h0);
    check("rst.wrap_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);

    // Streaming with decode always ready
    rst_n      = 1'b1;
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    tick();
    check_head("s1.c1", 32'h0);
    check("wrap.c1.pc", w_inst_pc, 32'hFFFF_FFFC);
    check("wrap.c1.data", w_inst_data, 32'h5A5A_FFFC);
    tick();
    check_head("s1.c2", 32'h4);
    check("wrap.c2.pc", w_inst_pc, 32'h0);
    check("wrap.c2.data", w_inst_data, 32'hA5A5_0000);
    tick();
    check_head("s1.c3", 32'h8);
    check("s1.fetch_pc", fetch_pc, 32'hC);

    // Redirect to unaligned target; popped pc 8 is acknowledged
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    check("rd.valid_gap", {31'b0, inst_valid}, 32'd0);
    check("rd.fetch_pc", fetch_pc, 32'h100);
    tick();
    check_head("rd.first", 32'h100);
    tick();
    check_head("rd.second", 32'h104);

    // Fill to 2 entries, then stop fetching and drain
    inst_ready = 1'b0;
    tick();
    check_head("fe.full", 32'h104);
    check("fe.full_fetch_pc", fetch_pc, 32'h10C);
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    tick();
    check_head("fe.pop1", 32'h108);
    tick();
    check("fe.empty", {31'b0, inst_valid}, 32'd0);
    check("fe.hold1", fetch_pc, 32'h10C);
    tick();
    check("fe.still_empty", {31'b0, inst_valid}, 32'd0);
    check("fe.hold2", fetch_pc, 32'h10C);
    fetch_en = 1'b1;
    tick();
    check_head("fe.resume", 32'h10C);

    // Back-to-back redirects: the second one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc = 32'h301;
    tick();
    redirect_valid = 1'b0;
    check("bb.valid_gap", {31'b0, inst_valid}, 32'd0);
    check("bb.fetch_pc", fetch_pc, 32'h300);
    inst_ready = 1'b0;
    tick();
    check_head("bb.first", 32'h300);
    tick();
    check_head("bb.full", 32'h300);
    check("bb.full_fetch_pc", fetch_pc, 32'h308);

    // Asynchronous reset with a full FIFO
    rst_n = 1'b0;
    #1;
    check("ar.valid", {31'b0, inst_valid}, 32'd0);
    check("ar.data", inst_data, 32'h0);
    check("ar.pc", inst_pc, 32'h0);
    check("ar.fetch_pc", fetch_pc, 32'h0);
    tick();
    rst_n = 1'b1;

    // Decode stall from reset: FIFO saturates, PC holds at 8
    tick();
    check_head("st.c1", 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head("st.hold", 32'h0);
      check("st.fetch_pc", fetch_pc, 32'h8);
    end
    inst_ready = 1'b1;
    tick();
    check_head("st.rel1", 32'h4);
    tick();
    check_head("st.rel2", 32'h8);
    tick();
    check_head("st.rel3", 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
